// File: rtl/vga_pic_bounce.sv
// Bouncing-square pattern generator for a VGA pixel pipeline. The box advances once per frame and reflects off the screen edges.
// Optional macro VGA_PIC_BOUNCE_COLOR_CYCLE_EN: when defined, the box colour changes on every bounce.
module vga_pic_bounce #(
    parameter logic [9:0] H_VALID  = 10'd640,
    parameter logic [9:0] V_VALID  = 10'd480,
    parameter logic [9:0] BOX_SIZE = 10'd16,
    parameter logic [9:0] STEP     = 10'd1
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    output logic [15:0] pix_data
);

    localparam int unsigned PW = 10;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned DW = 16;

    localparam logic [PW-1:0] PIX_NONE = 10'h3FF;
    localparam logic [CW-1:0] X_LIM    = CW'(H_VALID) - CW'(BOX_SIZE);
    localparam logic [CW-1:0] Y_LIM    = CW'(V_VALID) - CW'(BOX_SIZE);

    // One-axis motion rule; result is {bounce, dir, pos}.
    function automatic logic [PW+1:0] step_axis(input logic [PW-1:0] pos,
                                                input logic dir,
                                                input logic [CW-1:0] lim);
        logic [PW-1:0] npos;
        logic          ndir;
        logic          bnc;
        npos = pos;
        ndir = dir;
        bnc  = 1'b0;
        if (!dir) begin
            if (CW'(pos) + CW'(STEP) >= lim) begin
                npos = PW'(lim);
                ndir = 1'b1;
                bnc  = 1'b1;
            end else begin
                npos = pos + STEP;
            end
        end else begin
            if (pos <= STEP) begin
                npos = '0;
                ndir = 1'b0;
                bnc  = 1'b1;
            end else begin
                npos = pos - STEP;
            end
        end
        return {bnc, ndir, npos};
    endfunction

    logic [PW-1:0] x_pos_q, x_pos_d;
    logic [PW-1:0] y_pos_q, y_pos_d;
    logic          dir_x_q, dir_x_d;
    logic          dir_y_q, dir_y_d;
    logic          match_q, match_d;
    logic [DW-1:0] pix_data_q, pix_data_d;

    logic          frame_end_c;
    logic          inside_c;
    logic          bounce_c;
    logic [PW+1:0] x_step_c;
    logic [PW+1:0] y_step_c;
    logic [DW-1:0] box_color_c;

`ifdef VGA_PIC_BOUNCE_COLOR_CYCLE_EN
    logic [2:0] col_idx_q, col_idx_d;

    always_comb begin
        col_idx_d = col_idx_q;
        if (frame_end_c && bounce_c) begin
            col_idx_d = col_idx_q + 3'd1;
        end
    end

    always_comb begin
        box_color_c = 16'hFFFF;
        case (col_idx_q)
            3'd0: box_color_c = 16'hF800;
            3'd1: box_color_c = 16'hFC00;
            3'd2: box_color_c = 16'hFFE0;
            3'd3: box_color_c = 16'h07E0;
            3'd4: box_color_c = 16'h07FF;
            3'd5: box_color_c = 16'h001F;
            3'd6: box_color_c = 16'hF81F;
            default: box_color_c = 16'hFFFF;
        endcase
    end

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            col_idx_q <= '0;
        end else begin
            col_idx_q <= col_idx_d;
        end
    end
`else
    always_comb begin
        box_color_c = 16'hFFFF;
    end
`endif

    // Rising edge of the last-active-pixel match marks the end of a frame.
    always_comb begin
        match_d     = (pix_x == H_VALID - 10'd1) && (pix_y == V_VALID - 10'd1);
        frame_end_c = match_d && !match_q;
        x_step_c    = step_axis(x_pos_q, dir_x_q, X_LIM);
        y_step_c    = step_axis(y_pos_q, dir_y_q, Y_LIM);
        bounce_c    = x_step_c[PW+1] || y_step_c[PW+1];
    end

    always_comb begin
        x_pos_d = x_pos_q;
        y_pos_d = y_pos_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        if (frame_end_c) begin
            x_pos_d = x_step_c[PW-1:0];
            dir_x_d = x_step_c[PW];
            y_pos_d = y_step_c[PW-1:0];
            dir_y_d = y_step_c[PW];
        end
    end

    // Compares are done one bit wider so the box's far edge never wraps.
    always_comb begin
        inside_c = (pix_x != PIX_NONE) && (pix_y != PIX_NONE)
                && (CW'(pix_x) >= CW'(x_pos_q))
                && (CW'(pix_x) <  CW'(x_pos_q) + CW'(BOX_SIZE))
                && (CW'(pix_y) >= CW'(y_pos_q))
                && (CW'(pix_y) <  CW'(y_pos_q) + CW'(BOX_SIZE));
        pix_data_d = inside_c ? box_color_c : '0;
    end

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            x_pos_q    <= '0;
            y_pos_q    <= '0;
            dir_x_q    <= 1'b0;
            dir_y_q    <= 1'b0;
            match_q    <= 1'b0;
            pix_data_q <= '0;
        end else begin
            x_pos_q    <= x_pos_d;
            y_pos_q    <= y_pos_d;
            dir_x_q    <= dir_x_d;
            dir_y_q    <= dir_y_d;
            match_q    <= match_d;
            pix_data_q <= pix_data_d;
        end
    end

    assign pix_data = pix_data_q;

endmodule

// File: doc/vga_pic_bounce.md
VGA_PIC_BOUNCE -- requirements
Module: vga_pic_bounce

Interface
REQ-001 SHALL provide parameter H_VALID, default 10'd640, meaning active pixels per line.
REQ-002 SHALL provide parameter V_VALID, default 10'd480, meaning active lines per frame.
REQ-003 SHALL provide parameter BOX_SIZE, default 10'd16, meaning square edge length in pixels.
REQ-004 SHALL provide parameter STEP, default 10'd1, meaning pixels moved per frame on each axis.
REQ-005 SHALL have port vga_clk, input, 1, pixel clock; all logic in this single clock domain.
REQ-006 SHALL have port sys_rst, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port pix_x, input, 10, requested pixel column; 10'h3FF outside the active area.
REQ-008 SHALL have port pix_y, input, 10, requested pixel row; 10'h3FF outside the active area.
REQ-009 SHALL have port pix_data, output, 16, RGB565 pixel for the request of the previous cycle.

Function
REQ-010 SHALL hold state: x_pos[9:0], y_pos[9:0] (box top-left), dir_x (0 = right, 1 = left), dir_y (0 = down, 1 = up), col_idx[2:0].
REQ-011 SHALL assert an internal frame_end for exactly one cycle when pix_x == H_VALID-1 and pix_y == V_VALID-1, and only on the first cycle of that match.
REQ-012 SHALL update position and direction only on the clock edge following frame_end, leaving them stable for the whole active frame.
REQ-013 SHALL move right while dir_x == 0: if x_pos+STEP >= H_VALID-BOX_SIZE, set x_pos = H_VALID-BOX_SIZE and dir_x = 1 (x-bounce); otherwise x_pos += STEP.
REQ-014 SHALL move left while dir_x == 1: if x_pos <= STEP, set x_pos = 0 and dir_x = 0 (x-bounce); otherwise x_pos -= STEP.
REQ-015 SHALL apply the REQ-013/014 rules to y_pos, dir_y and V_VALID for the vertical axis (y-bounce).
REQ-016 SHALL increment col_idx by exactly 1, modulo 8, on any frame update with an x-bounce, a y-bounce, or both (a corner hit advances once).
REQ-017 SHALL classify a pixel as inside when x_pos <= pix_x < x_pos+BOX_SIZE and y_pos <= pix_y < y_pos+BOX_SIZE, using 11-bit compare sums so nothing wraps.
REQ-018 SHALL register pix_data with a latency of exactly 1 vga_clk; the value is the box colour when inside, else 16'h0000.
REQ-019 SHALL output 16'h0000 whenever pix_x or pix_y equals 10'h3FF.
REQ-020 SHALL use this box colour table, indexed by col_idx 0..7: F800, FC00, FFE0, 07E0, 07FF, 001F, F81F, FFFF.

Reset
REQ-021 SHALL, while sys_rst is high and regardless of clock, force x_pos = 0, y_pos = 0, dir_x = 0, dir_y = 0, col_idx = 0, pix_data = 16'h0000 and the frame_end edge detector clear.
REQ-022 SHALL, after sys_rst is released mid-frame, resume with no frame update until the next frame_end.

Configuration
REQ-023 SHALL, with macro VGA_PIC_BOUNCE_COLOR_CYCLE_EN defined, implement col_idx and the colour table (REQ-016, REQ-020).
REQ-024 SHALL, without VGA_PIC_BOUNCE_COLOR_CYCLE_EN, omit col_idx and drive the box constant 16'hFFFF; motion and bounces are unchanged.

Verification
REQ-025 Reset, then request (0,0) and (16,0) -> pix_data 16'hF800 and 16'h0000, each one cycle after its request.
REQ-026 Hold (639,479) for 3 cycles -> a single update only; x_pos = 1, y_pos = 1; (0,0) then renders 16'h0000.
REQ-027 Run 624 frames with defaults -> x_pos = 624, dir_x = 1; col_idx = 2 (y-bounce at frame 464, x-bounce at frame 624).
REQ-028 Set H_VALID = V_VALID = 64 and run 48 frames -> corner hit: x_pos = y_pos = 48, both dirs flip, col_idx = 1 (advanced once).
REQ-029 Request pix_x = 10'h3FF with the box at the origin -> pix_data 16'h0000.
REQ-030 Assert sys_rst mid-frame at x_pos = 100 -> pix_data = 0 and x_pos = 0 immediately, without waiting for a clock edge.
